// File: rtl/apb_slave.sv
// APB completer backed by a DEPTH-word register file, with a configurable number of
// wait states and PSLVERR for out-of-range word addresses.
module apb_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pwrite,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q;
    state_t                phase;
    logic [3:0]            cnt_q;
    logic [IDX_W-1:0]      addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic setup_err;
    logic done;

    // SETUP is the bus setup cycle itself: it is recognised from psel/penable while
    // the registered state is not ACCESS, so a zero-wait transfer fits in two cycles.
    always_comb begin
        phase = IDLE;
        if (state_q == ACCESS)
            phase = ACCESS;
        else if (psel && !penable)
            phase = SETUP;
    end

    assign setup_err = (paddr >= ADDR_WIDTH'(DEPTH));
    assign done      = (state_q == ACCESS) && psel && penable && (cnt_q == 4'(WAIT_STATES));

    assign pready  = done;
    assign pslverr = done && err_q;
    assign prdata  = (done && write_q) ? '0 : rdata_q;

    always_ff @(posedge pclk) begin
        if (presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            case (phase)
                SETUP: begin
                    addr_q  <= paddr[IDX_W-1:0];
                    wdata_q <= pwdata;
                    write_q <= pwrite;
                    err_q   <= setup_err;
                    if (!pwrite)
                        rdata_q <= setup_err ? '0 : mem[paddr[IDX_W-1:0]];
                    cnt_q   <= '0;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (!(psel && penable)) begin
                        // requester abandoned the transfer: drop it without side effects
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (!done) begin
                        cnt_q <= cnt_q + 4'd1;
                    end else begin
                        if (write_q && !err_q)
                            mem[addr_q] <= wdata_q;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: three instances (0, 2 and 3 wait states) on a shared bus with
// per-instance psel, checked against an array model of each register file.
module tb_apb_slave;

    localparam int DEPTH = 16;
    localparam int NINST = 3;

    logic        pclk;
    logic        presetn;
    logic [31:0] paddr;
    logic [NINST-1:0] psel;
    logic        penable;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [31:0] prdata_v  [NINST];
    logic        pready_v  [NINST];
    logic        pslverr_v [NINST];

    logic [31:0] ref_mem [NINST][DEPTH];
    int tests = 0;
    int fails = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        apb_slave #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .DEPTH      (DEPTH),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .pclk   (pclk),
            .presetn(presetn),
            .paddr  (paddr),
            .psel   (psel[g]),
            .penable(penable),
            .pwdata (pwdata),
            .pwrite (pwrite),
            .prdata (prdata_v[g]),
            .pready (pready_v[g]),
            .pslverr(pslverr_v[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NINST; k++)
            for (int a = 0; a < DEPTH; a++)
                ref_mem[k][a] = '0;
    endtask

    task automatic go_idle();
        @(negedge pclk);
        psel    = '0;
        penable = 1'b0;
    endtask

    // One complete transfer on instance k; compares data, error flag and length
    // against the model, then updates the model.
    task automatic xfer(input int k, input logic [31:0] addr, input bit wr,
                        input logic [31:0] data, input bit b2b, input bit scramble);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          cyc;
        bit          got;
        logic [31:0] obs_rd;
        logic        obs_err;
        exp_err = (addr >= 32'(DEPTH));
        exp_rd  = (wr || exp_err) ? 32'h0 : ref_mem[k][addr[3:0]];
        obs_rd  = 'x;
        obs_err = 1'bx;
        if (!b2b) go_idle();
        @(negedge pclk);
        psel    = '0;
        psel[k] = 1'b1;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        #1 check("setup_pready", 64'(pready_v[k]), 64'd0);
        @(negedge pclk);
        penable = 1'b1;
        if (scramble) begin
            paddr  = $urandom;
            pwdata = $urandom;
            pwrite = ~wr;
        end
        cyc = 1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            cyc++;
            if (pready_v[k]) begin
                got     = 1;
                obs_rd  = prdata_v[k];
                obs_err = pslverr_v[k];
            end else begin
                check("wait_pslverr", 64'(pslverr_v[k]), 64'd0);
                @(negedge pclk);
            end
        end
        check("done_in_time", 64'(got), 64'd1);
        check("cycles", 64'(cyc), 64'(2 + ws_of(k)));
        check("pslverr", 64'(obs_err), 64'(exp_err));
        check(wr ? "wr_prdata" : "rd_prdata", 64'(obs_rd), 64'(exp_rd));
        if (wr && !exp_err)
            ref_mem[k][addr[3:0]] = data;
    endtask

    initial begin
        presetn = 1'b1;
        psel    = '0;
        penable = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pwrite  = 1'b0;
        clear_model();

        // reset
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        for (int k = 0; k < NINST; k++) begin
            check("rst_pready", 64'(pready_v[k]), 64'd0);
            check("rst_pslverr", 64'(pslverr_v[k]), 64'd0);
            check("rst_prdata", 64'(prdata_v[k]), 64'd0);
        end
        for (int a = 0; a < DEPTH; a++)
            xfer(0, 32'(a), 0, 32'h0, 1, 0);

        // write/read
        xfer(0, 32'd5, 1, 32'hDEADBEEF, 0, 0);
        xfer(0, 32'd5, 0, 32'h0, 0, 0);

        // back-to-back fill and readback
        for (int a = 0; a < DEPTH; a++)
            xfer(0, 32'(a), 1, 32'(a * 32'h11), 1, 0);
        for (int a = 0; a < DEPTH; a++)
            xfer(0, 32'(a), 0, 32'h0, 1, 0);

        // illegal addresses, including one that would alias if upper bits were dropped
        xfer(0, 32'd16, 1, 32'h1234, 0, 0);
        xfer(0, 32'd16, 0, 32'h0, 1, 0);
        xfer(0, 32'd0, 0, 32'h0, 1, 0);
        xfer(0, 32'h0001_0003, 1, 32'hBAD0BAD0, 1, 0);
        xfer(0, 32'd3, 0, 32'h0, 1, 0);

        // wait states
        xfer(2, 32'd2, 1, 32'hCAFE0002, 0, 0);
        xfer(2, 32'd2, 0, 32'h0, 0, 0);

        // abort by dropping psel mid-ACCESS
        xfer(1, 32'd7, 1, 32'hAAAA0007, 0, 0);
        @(negedge pclk);
        psel = 3'b010; penable = 1'b0; paddr = 32'd7; pwrite = 1'b1; pwdata = 32'h5555;
        @(negedge pclk);
        penable = 1'b1;
        #1 check("abort_wait_pready", 64'(pready_v[1]), 64'd0);
        @(negedge pclk);
        psel = '0; penable = 1'b0;
        #1 check("abort_pready", 64'(pready_v[1]), 64'd0);
        @(negedge pclk);
        #1 check("abort_idle_pready", 64'(pready_v[1]), 64'd0);
        xfer(1, 32'd7, 0, 32'h0, 0, 0);

        // reset in ACCESS
        @(negedge pclk);
        psel = 3'b010; penable = 1'b0; paddr = 32'd7; pwrite = 1'b1; pwdata = 32'h7777;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        presetn = 1'b0; psel = '0; penable = 1'b0;
        clear_model();
        #1;
        check("midrst_pready", 64'(pready_v[1]), 64'd0);
        check("midrst_pslverr", 64'(pslverr_v[1]), 64'd0);
        check("midrst_prdata", 64'(prdata_v[1]), 64'd0);
        xfer(1, 32'd7, 0, 32'h0, 0, 0);

        // randomized traffic, with bus attributes scrambled during ACCESS
        for (int n = 0; n < 150; n++) begin
            int          k;
            logic [31:0] addr;
            k    = $urandom_range(0, NINST - 1);
            addr = 32'($urandom_range(0, 19));
            if ($urandom_range(0, 9) == 0)
                addr = $urandom | 32'h100;
            xfer(k, addr, bit'($urandom_range(0, 1)), $urandom,
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        go_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
Name: apb_slave

Overview:
- APB (AMBA 3) completer with a word-addressed register memory; single clock domain.
- Sits behind the abp_if interface, which bundles the APB bus signals between the requester driver/monitor and this slave.
- Handles read and write transfers, with optional wait states and PSLVERR on illegal addresses.

Parameters:
ADDR_WIDTH, 32, width of paddr.
DATA_WIDTH, 32, width of pwdata/prdata.
DEPTH, 16, number of memory words; legal addresses 0..DEPTH-1.
WAIT_STATES, 0, number of ACCESS cycles with pready=0 before completion (0..15).

Ports:
pclk  input  1  APB clock; all logic on rising edge.
presetn  input  1  reset, synchronous and active-high (1 = reset) despite the name.
paddr  input  ADDR_WIDTH  word address.
psel  input  1  slave select.
penable  input  1  access phase strobe.
pwdata  input  DATA_WIDTH  write data.
pwrite  input  1  1 = write, 0 = read.
prdata  output  DATA_WIDTH  read data, valid when pready=1 on a read.
pready  output  1  transfer completion.
pslverr  output  1  error response, valid only when pready=1.

Behaviour:
- The interface is one clock (pclk) and a synchronous, active-high reset named presetn, sampled on the pclk rising edge.
- Reset (presetn=1 at an edge):
  - all DEPTH memory words cleared to 0;
  - FSM goes to IDLE and wait counter clears;
  - prdata=0, pready=0, pslverr=0.
  - Reset mid-transfer aborts it with no memory write.
- FSM states IDLE, SETUP, ACCESS.
  - IDLE: psel=1 & penable=0 -> SETUP. Anything else stays IDLE; penable=1 without a prior setup is ignored.
  - SETUP: latch paddr, pwrite, pwdata, and the error flag (paddr >= DEPTH). For reads, latch mem[paddr] into prdata, or 0 if the address is illegal. Go to ACCESS unconditionally.
  - ACCESS, while psel=1 & penable=1:
    - Counter < WAIT_STATES: pready=0, counter increments.
    - Counter == WAIT_STATES: pready=1 (combinational from state and counter). pslverr = latched error flag.
    - At the edge ending the pready=1 cycle, a legal write stores latched pwdata into mem[latched paddr]. State then goes to SETUP if psel=1 & penable=0, otherwise IDLE; counter clears.
  - ACCESS with psel or penable dropped early (protocol violation): abort to IDLE, no write, pready stays 0.
- Outputs:
  - pready and pslverr are 0 outside the completion cycle.
  - prdata holds its last value except when updated in SETUP of a read.
  - prdata is 0 in the completion cycle of a write.
- Errors: paddr >= DEPTH sets pslverr=1 at completion. A write to an illegal address leaves memory unchanged; a read returns prdata=0. Upper address bits are never aliased.
- With WAIT_STATES=0 every transfer takes exactly 2 cycles (SETUP + ACCESS). Back-to-back transfers are allowed with no IDLE cycle between them.
- A read of a location in the cycle after a write to it returns the new data, because the write commits before the next SETUP latch.
- Transfer attributes are taken from the SETUP-cycle latch. Changes to paddr/pwdata/pwrite during ACCESS are ignored.

Test Plan:
- Reset: presetn=1 for 2 cycles, then 0 -> pready=0, pslverr=0, prdata=0; reading addr 0..15 returns 0 with pslverr=0.
- Write/read: write 0xDEADBEEF to addr 5, then read addr 5 -> write completes with pready=1, pslverr=0 in cycle 2; read completes in cycle 2 with prdata=0xDEADBEEF.
- Back-to-back: write addr 0..15 with data = addr*0x11 and no idle cycles, then read all back -> each readback matches, each transfer takes 2 cycles, pslverr always 0.
- Error: write 0x1234 to addr 16, then read addr 16 and read addr 0 -> both addr-16 transfers give pslverr=1 and the read gives prdata=0; addr 0 still holds its prior value.
- Wait states (WAIT_STATES=3): read addr 2 -> pready stays 0 for 3 ACCESS cycles and rises in the 4th, with prdata valid.
- Abort/reset: drop psel during ACCESS of a write to addr 7 (WAIT_STATES=2), and separately assert presetn in ACCESS -> no write occurs, pready=0, and a subsequent read of addr 7 returns the old value (0 after reset).
